// File: rtl/sram_banked_dual_pkg.sv
// Shared types for the banked dual-port SRAM slice.
package sram_banked_dual_pkg;

    typedef enum logic {
        RR_A = 1'b0,
        RR_B = 1'b1
    } rr_sel_e;

endpackage

// File: rtl/sram_bank_arb.sv
// Two-requester round-robin arbiter for one bank.
module sram_bank_arb
    import sram_banked_dual_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic grant_a,
    output logic grant_b
);

    rr_sel_e rr;
    rr_sel_e rr_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr <= RR_A;
        end else begin
            rr <= rr_next;
        end
    end

    // Pointer only moves on contention, handing priority to the loser.
    always_comb begin
        rr_next = rr;
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (req_a && req_b) begin
            if (rr == RR_A) begin
                grant_a = 1'b1;
                rr_next = RR_B;
            end else begin
                grant_b = 1'b1;
                rr_next = RR_A;
            end
        end else begin
            grant_a = req_a;
            grant_b = req_b;
        end
    end

endmodule

// File: rtl/sram_wrapper.sv
// Single-ported synchronous SRAM macro wrapper with active-low CS/WE/BE pins.
module sram_wrapper #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 512
) (
    input  logic                       clk,
    input  logic                       cs_n,
    input  logic                       we_n,
    input  logic [WIDTH/8-1:0]         be_n,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata
);

    localparam int unsigned BEW = WIDTH / 8;

    logic [WIDTH-1:0] mem [DEPTH];

    // Byte-masked write, registered read; read data holds on write cycles.
    always_ff @(posedge clk) begin
        if (!cs_n) begin
            if (!we_n) begin
                for (int i = 0; i < BEW; i++) begin
                    if (!be_n[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sram_banked_dual.sv
// Two-port bank-interleaved RAM: per-bank arbitration over single-ported macros.
module sram_banked_dual #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 2048,
    parameter int unsigned N_BANKS = 4,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               a_req,
    output logic               a_ready,
    input  logic               a_we,
    input  logic [WIDTH/8-1:0] a_be,
    input  logic [AW-1:0]      a_addr,
    input  logic [WIDTH-1:0]   a_wdata,
    output logic               a_rvalid,
    output logic [WIDTH-1:0]   a_rdata,
    input  logic               b_req,
    output logic               b_ready,
    input  logic               b_we,
    input  logic [WIDTH/8-1:0] b_be,
    input  logic [AW-1:0]      b_addr,
    input  logic [WIDTH-1:0]   b_wdata,
    output logic               b_rvalid,
    output logic [WIDTH-1:0]   b_rdata
);

    localparam int unsigned BW     = $clog2(N_BANKS);
    localparam int unsigned RW     = AW - BW;
    localparam int unsigned BDEPTH = DEPTH / N_BANKS;

    logic [BW-1:0]      bank_a;
    logic [BW-1:0]      bank_b;
    logic [RW-1:0]      row_a;
    logic [RW-1:0]      row_b;
    logic [N_BANKS-1:0] gnt_a;
    logic [N_BANKS-1:0] gnt_b;
    logic [WIDTH-1:0]   bank_rdata [N_BANKS];

    logic               rd_pend_a;
    logic               rd_pend_b;
    logic [BW-1:0]      bank_dph_a;
    logic [BW-1:0]      bank_dph_b;

    assign bank_a = a_addr[BW-1:0];
    assign bank_b = b_addr[BW-1:0];
    assign row_a  = a_addr[AW-1:BW];
    assign row_b  = b_addr[AW-1:BW];

    for (genvar k = 0; k < N_BANKS; k++) begin : g_bank
        sram_bank_arb u_arb (
            .clk     (clk),
            .rst_n   (rst_n),
            .req_a   (a_req && (bank_a == BW'(k))),
            .req_b   (b_req && (bank_b == BW'(k))),
            .grant_a (gnt_a[k]),
            .grant_b (gnt_b[k])
        );

        // Macro pins are driven by whichever port holds the grant.
        sram_wrapper #(
            .WIDTH (WIDTH),
            .DEPTH (BDEPTH)
        ) u_sram (
            .clk   (clk),
            .cs_n  (~(gnt_a[k] | gnt_b[k])),
            .we_n  (~(gnt_a[k] ? a_we : b_we)),
            .be_n  (~(gnt_a[k] ? a_be : b_be)),
            .addr  (gnt_a[k] ? row_a : row_b),
            .wdata (gnt_a[k] ? a_wdata : b_wdata),
            .rdata (bank_rdata[k])
        );
    end

    assign a_ready = |gnt_a;
    assign b_ready = |gnt_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend_a <= 1'b0;
            rd_pend_b <= 1'b0;
        end else begin
            rd_pend_a <= a_req && a_ready && !a_we;
            rd_pend_b <= b_req && b_ready && !b_we;
        end
    end

    // Remembers which bank to steer back to each port in the data phase.
    always_ff @(posedge clk) begin
        if (a_req && a_ready) begin
            bank_dph_a <= bank_a;
        end
        if (b_req && b_ready) begin
            bank_dph_b <= bank_b;
        end
    end

    assign a_rvalid = rd_pend_a;
    assign b_rvalid = rd_pend_b;
    assign a_rdata  = bank_rdata[bank_dph_a];
    assign b_rdata  = bank_rdata[bank_dph_b];

endmodule

// File: tb/tb_sram_banked_dual.sv
// Scoreboard bench for sram_banked_dual: reference memory model plus rvalid monitor.
module tb_sram_banked_dual;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned DEPTH   = 2048;
    localparam int unsigned N_BANKS = 4;
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned NADDR   = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             a_req, a_ready, a_we, a_rvalid;
    logic [3:0]       a_be;
    logic [AW-1:0]    a_addr;
    logic [31:0]      a_wdata, a_rdata;
    logic             b_req, b_ready, b_we, b_rvalid;
    logic [3:0]       b_be;
    logic [AW-1:0]    b_addr;
    logic [31:0]      b_wdata, b_rdata;

    sram_banked_dual #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N_BANKS(N_BANKS)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_ready(a_ready), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_ready(b_ready), .b_we(b_we), .b_be(b_be), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] model_mem [NADDR];
    bit          model_rr [N_BANKS];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    bit          act_ga, act_gb;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    // One clock: predict grants from the rules, compare ready, update the model.
    task automatic step();
        int  ba, bb;
        bit  ga, gb, contend;
        exp_t e;
        @(negedge clk);
        ba = int'(a_addr) % N_BANKS;
        bb = int'(b_addr) % N_BANKS;
        contend = a_req && b_req && (ba == bb);
        ga = a_req && (!contend || !model_rr[ba]);
        gb = b_req && (!contend || model_rr[bb]);
        check("a_ready", 32'(a_ready), 32'(ga));
        check("b_ready", 32'(b_ready), 32'(gb));
        act_ga = a_ready;
        act_gb = b_ready;
        if (ga) begin
            if (a_we) model_mem[a_addr % NADDR] = byte_merge(model_mem[a_addr % NADDR], a_wdata, a_be);
            else if (rst_n) begin e.data = model_mem[a_addr % NADDR]; e.due = cyc + 1; qa.push_back(e); end
        end
        if (gb) begin
            if (b_we) model_mem[b_addr % NADDR] = byte_merge(model_mem[b_addr % NADDR], b_wdata, b_be);
            else if (rst_n) begin e.data = model_mem[b_addr % NADDR]; e.due = cyc + 1; qb.push_back(e); end
        end
        if (!rst_n) begin
            for (int k = 0; k < N_BANKS; k++) model_rr[k] = 1'b0;
        end else if (contend) begin
            model_rr[ba] = !model_rr[ba];
        end
        @(posedge clk);
        #1;
    endtask

    // Step until every raised request has been accepted once.
    task automatic run_until_done(input string name);
        int n;
        n = 0;
        while ((a_req || b_req) && n < 8) begin
            step();
            if (act_ga) a_req = 1'b0;
            if (act_gb) b_req = 1'b0;
            n++;
        end
        if (a_req || b_req) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: requests not accepted within 8 cycles", name);
            a_req = 1'b0;
            b_req = 1'b0;
        end
    endtask

    task automatic set_a(input bit we, input logic [AW-1:0] addr, input logic [3:0] be, input logic [31:0] wd);
        a_req = 1'b1; a_we = we; a_addr = addr; a_be = be; a_wdata = wd;
    endtask

    task automatic set_b(input bit we, input logic [AW-1:0] addr, input logic [3:0] be, input logic [31:0] wd);
        b_req = 1'b1; b_we = we; b_addr = addr; b_be = be; b_wdata = wd;
    endtask

    // Monitor: every rvalid must match the head of its port's queue, on time.
    always @(negedge clk) begin
        if (mon_en) begin
            if (a_rvalid === 1'b1) begin
                if (qa.size() == 0) begin
                    check("a_spurious_rvalid", 32'(a_rvalid), 32'd0);
                end else begin
                    check("a_rdata", a_rdata, qa[0].data);
                    check("a_latency", 32'(cyc), 32'(qa[0].due));
                    void'(qa.pop_front());
                end
            end else if (qa.size() != 0 && qa[0].due <= cyc) begin
                check("a_missing_rvalid", 32'(a_rvalid), 32'd1);
                void'(qa.pop_front());
            end
            if (b_rvalid === 1'b1) begin
                if (qb.size() == 0) begin
                    check("b_spurious_rvalid", 32'(b_rvalid), 32'd0);
                end else begin
                    check("b_rdata", b_rdata, qb[0].data);
                    check("b_latency", 32'(cyc), 32'(qb[0].due));
                    void'(qb.pop_front());
                end
            end else if (qb.size() != 0 && qb[0].due <= cyc) begin
                check("b_missing_rvalid", 32'(b_rvalid), 32'd1);
                void'(qb.pop_front());
            end
        end
    end

    initial begin
        bit exp_pat [4];
        exp_pat[0] = 1'b0; exp_pat[1] = 1'b1; exp_pat[2] = 1'b0; exp_pat[3] = 1'b1;
        a_req = 0; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0;
        for (int i = 0; i < N_BANKS; i++) model_rr[i] = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Idle after reset: no ready, no rvalid.
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_a_rvalid", 32'(a_rvalid), 32'd0);
            check("idle_b_rvalid", 32'(b_rvalid), 32'd0);
        end

        // Preload the exercised window: a takes even, b odd addresses.
        for (int i = 0; i < NADDR; i += 2) begin
            set_a(1'b1, AW'(i),     4'hF, 32'(i)     * 32'h01010101 ^ 32'hC3C3C3C3);
            set_b(1'b1, AW'(i + 1), 4'hF, 32'(i + 1) * 32'h01010101 ^ 32'hC3C3C3C3);
            run_until_done("preload");
        end

        // Partial byte-enable write followed by a read of the same word.
        set_a(1'b1, AW'(5), 4'b0101, 32'hDEADBEEF);
        run_until_done("be_write");
        set_a(1'b0, AW'(5), 4'h0, 32'h0);
        run_until_done("be_read");
        step();
        check("be_merge", model_mem[5],
              {8'hC3 ^ 8'h05, 8'hAD, 8'hC3 ^ 8'h05, 8'hEF});

        // Different banks in the same cycle: both accepted together.
        set_a(1'b0, AW'(4), 4'h0, 32'h0);
        set_b(1'b0, AW'(5), 4'h0, 32'h0);
        step();
        check("diff_bank_a_ready", 32'(act_ga), 32'd1);
        check("diff_bank_b_ready", 32'(act_gb), 32'd1);
        a_req = 0; b_req = 0;

        // Both hammer addr 8 with req held: grants alternate a, b, a, b.
        set_a(1'b0, AW'(8), 4'h0, 32'h0);
        set_b(1'b0, AW'(8), 4'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_grant_b", 32'(act_gb), 32'(exp_pat[i]));
            check("rr_grant_a", 32'(act_ga), 32'(!exp_pat[i]));
        end
        a_req = 0; b_req = 0;
        step();

        // Same-cycle write (a) and read (b) of one word with rr=0: read sees write.
        set_a(1'b1, AW'(8), 4'hF, 32'h11111111);
        set_b(1'b0, AW'(8), 4'h0, 32'h0);
        run_until_done("wr_rd_conflict");
        step();
        check("wr_rd_model", model_mem[8], 32'h11111111);

        // Reset in the cycle a read is accepted: no rvalid, storage retained.
        set_a(1'b0, AW'(6), 4'h0, 32'h0);
        rst_n = 1'b0;
        step();
        a_req = 1'b0;
        rst_n = 1'b1;
        step();
        check("rst_no_rvalid", 32'(a_rvalid), 32'd0);
        set_a(1'b0, AW'(6), 4'h0, 32'h0);
        run_until_done("post_rst_read");
        step();

        // Randomized traffic with requests held until accepted.
        for (int n = 0; n < 2000; n++) begin
            if (!a_req || act_ga) begin
                a_req = ($urandom_range(0, 3) != 0);
                a_we = $urandom_range(0, 1) == 1;
                a_addr = AW'($urandom_range(0, NADDR - 1));
                a_be = 4'($urandom);
                a_wdata = $urandom;
            end
            if (!b_req || act_gb) begin
                b_req = ($urandom_range(0, 3) != 0);
                b_we = $urandom_range(0, 1) == 1;
                b_addr = AW'($urandom_range(0, NADDR - 1));
                b_be = 4'($urandom);
                b_wdata = $urandom;
            end
            act_ga = 0; act_gb = 0;
            step();
        end
        a_req = 0; b_req = 0;
        repeat (3) step();
        check("qa_drained", 32'(qa.size()), 32'd0);
        check("qb_drained", 32'(qb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
